// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, default sampling geometry and
// the character width.
package uart_pkg;

    localparam int unsigned DEF_SAMPLES_PER_BIT = 8;
    localparam int unsigned DEF_VOTE_CENTER     = 4;
    localparam int unsigned DATA_BITS           = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

    function automatic logic majority3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an idle-high asynchronous UART line; resets to 1
// so a reset never looks like a start bit.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], din};
        end
    end

    assign dout = sync_q[1];

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receive sampler: start-bit qualification, 3-sample majority voting per
// bit cell, optional parity and stop-bit checks, one valid pulse per frame.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int unsigned SAMPLES_PER_BIT = DEF_SAMPLES_PER_BIT,
    parameter int unsigned VOTE_CENTER     = DEF_VOTE_CENTER
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 AcqSig_i,
    input  logic                 Rx_i,
    input  logic                 ParityEn_i,
    input  logic                 ParityOdd_i,
    output logic [DATA_BITS-1:0] Data_o,
    output logic                 DataValid_o,
    output logic                 ParityErr_o,
    output logic                 FrameErr_o,
    output logic                 Busy_o
);

    localparam int unsigned CNT_W = $clog2(SAMPLES_PER_BIT);
    localparam int unsigned IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] VOTE_LO  = CNT_W'(VOTE_CENTER - 1);
    localparam logic [CNT_W-1:0] VOTE_MID = CNT_W'(VOTE_CENTER);
    localparam logic [CNT_W-1:0] VOTE_HI  = CNT_W'(VOTE_CENTER + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLES_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    rx_state_t            state;
    rx_state_t            next_state;
    logic                 sync_rx;
    logic [CNT_W-1:0]     sample_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [1:0]           vote_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_en_q;
    logic                 par_odd_q;
    logic                 par_err_q;

    logic                 vote_lo_c;
    logic                 vote_mid_c;
    logic                 decide_c;
    logic                 wrap_c;
    logic                 bit_c;

    uart_rx_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (Rx_i),
        .dout (sync_rx)
    );

    // Third vote is taken live, so the bit decision lands on that strobe.
    assign bit_c = majority3({vote_q[1], vote_q[0], sync_rx});

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (AcqSig_i) begin
            unique case (state)
                IDLE:   if (!sync_rx) next_state = START;
                START: begin
                    if (decide_c && bit_c) begin
                        next_state = IDLE;
                    end else if (wrap_c) begin
                        next_state = DATA;
                    end
                end
                DATA: begin
                    if (wrap_c && (bit_idx == IDX_LAST)) begin
                        next_state = par_en_q ? PARITY : STOP;
                    end
                end
                PARITY: if (wrap_c) next_state = STOP;
                STOP:   if (decide_c) next_state = bit_c ? IDLE : BREAK;
                BREAK:  if (sync_rx) next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Sampling strobes are only meaningful inside a bit cell.
    always_comb begin
        vote_lo_c  = 1'b0;
        vote_mid_c = 1'b0;
        decide_c   = 1'b0;
        wrap_c     = 1'b0;
        if (AcqSig_i) begin
            unique case (state)
                START, DATA, PARITY, STOP: begin
                    vote_lo_c  = (sample_cnt == VOTE_LO);
                    vote_mid_c = (sample_cnt == VOTE_MID);
                    decide_c   = (sample_cnt == VOTE_HI);
                    wrap_c     = (sample_cnt == CNT_LAST);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_cnt  <= '0;
            bit_idx     <= '0;
            vote_q      <= '0;
            shift_q     <= '0;
            par_en_q    <= 1'b0;
            par_odd_q   <= 1'b0;
            par_err_q   <= 1'b0;
            Data_o      <= '0;
            DataValid_o <= 1'b0;
            ParityErr_o <= 1'b0;
            FrameErr_o  <= 1'b0;
            Busy_o      <= 1'b0;
        end else begin
            DataValid_o <= 1'b0;
            if (AcqSig_i) begin
                Busy_o <= (next_state != IDLE);
                // The detection strobe is sample 0 of the start cell.
                if (state == IDLE) begin
                    sample_cnt <= (next_state == START) ? CNT_W'(1) : '0;
                end else if ((next_state == IDLE) || (next_state == BREAK) || wrap_c) begin
                    sample_cnt <= '0;
                end else begin
                    sample_cnt <= sample_cnt + CNT_W'(1);
                end
            end
            if (vote_lo_c) begin
                vote_q[0] <= sync_rx;
            end
            if (vote_mid_c) begin
                vote_q[1] <= sync_rx;
            end
            if (decide_c) begin
                unique case (state)
                    START: begin
                        if (!bit_c) begin
                            par_en_q  <= ParityEn_i;
                            par_odd_q <= ParityOdd_i;
                        end
                    end
                    DATA:   shift_q   <= {bit_c, shift_q[DATA_BITS-1:1]};
                    PARITY: par_err_q <= ((^shift_q) ^ bit_c) != par_odd_q;
                    STOP: begin
                        Data_o      <= shift_q;
                        ParityErr_o <= par_en_q & par_err_q;
                        FrameErr_o  <= ~bit_c;
                        DataValid_o <= 1'b1;
                    end
                    default: ;
                endcase
            end
            if (wrap_c) begin
                if (state == START) begin
                    bit_idx <= '0;
                end else if (state == DATA) begin
                    bit_idx <= bit_idx + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed frames against uart_rx_sampler; a scoreboard queue holds the
// expected character/flags and a monitor checks every DataValid_o pulse.
module tb_uart_rx_sampler;

    localparam int unsigned BIT_CLKS = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       acq;
    logic       rx;
    logic       par_en;
    logic       par_odd;
    logic [7:0] data;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    uart_rx_sampler dut (
        .clk         (clk),
        .rst         (rst),
        .AcqSig_i    (acq),
        .Rx_i        (rx),
        .ParityEn_i  (par_en),
        .ParityOdd_i (par_odd),
        .Data_o      (data),
        .DataValid_o (data_valid),
        .ParityErr_o (parity_err),
        .FrameErr_o  (frame_err),
        .Busy_o      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Strobe every 4 clk
    initial begin
        int div = 0;
        acq = 1'b0;
        forever begin
            @(negedge clk);
            div = (div + 1) % 4;
            acq = (div == 0);
        end
    end

    // Monitor: every valid pulse must match the oldest expected frame
    always @(negedge clk) begin
        if (data_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_valid: got data %h perr %b ferr %b expected no frame at %0t",
                         data, parity_err, frame_err, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("frame_data", data, e.data);
                check("frame_parity_err", 8'(parity_err), 8'(e.perr));
                check("frame_frame_err", 8'(frame_err), 8'(e.ferr));
            end
        end
    end

    task automatic hold_bit(input logic v, input int glitch);
        for (int c = 0; c < BIT_CLKS; c++) begin
            rx = (glitch != 0 && c >= 14 && c < 18) ? ~v : v;
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                              input logic stop, input int glitch_bit);
        hold_bit(1'b0, 0);
        for (int i = 0; i < 8; i++) hold_bit(d[i], int'(i == glitch_bit));
        if (pen) hold_bit(pbit, 0);
        hold_bit(stop, 0);
        rx = 1'b1;
    endtask

    task automatic push(input logic [7:0] d, input logic pe, input logic fe);
        exp_t e;
        e.data = d;
        e.perr = pe;
        e.ferr = fe;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int bits);
        rx = 1'b1;
        repeat (bits * BIT_CLKS) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_data"}, data, 8'h00);
        check({tag, "_valid"}, 8'(data_valid), 8'h0);
        check({tag, "_parity_err"}, 8'(parity_err), 8'h0);
        check({tag, "_frame_err"}, 8'(frame_err), 8'h0);
        check({tag, "_busy"}, 8'(busy), 8'h0);
    endtask

    initial begin
        rst     = 1'b1;
        rx      = 1'b1;
        par_en  = 1'b0;
        par_odd = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_values("reset");
        idle(2);

        // 0xA5, no parity, good stop
        push(8'hA5, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, -1);
        idle(1);
        check("busy_after_a5", 8'(busy), 8'h0);

        // 0x37 odd parity: parity bit 0 is correct (five ones), 1 is wrong
        par_en  = 1'b1;
        par_odd = 1'b1;
        push(8'h37, 1'b0, 1'b0);
        send_frame(8'h37, 1'b1, 1'b0, 1'b1, -1);
        idle(1);
        push(8'h37, 1'b1, 1'b0);
        send_frame(8'h37, 1'b1, 1'b1, 1'b1, -1);
        idle(1);
        check("busy_after_parity", 8'(busy), 8'h0);
        par_en  = 1'b0;
        par_odd = 1'b0;

        // 6-clk glitch on an idle line: start is rejected, nothing delivered
        rx = 1'b0;
        repeat (6) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        check("busy_glitch_detect", 8'(busy), 8'h1);
        repeat (BIT_CLKS) @(negedge clk);
        check("busy_glitch_release", 8'(busy), 8'h0);
        idle(1);

        // 0x00 with stop=0 then line held low: one frame with frame error
        push(8'h00, 1'b0, 1'b1);
        send_frame(8'h00, 1'b0, 1'b0, 1'b0, -1);
        rx = 1'b0;
        repeat (3 * BIT_CLKS) @(negedge clk);
        check("busy_in_break", 8'(busy), 8'h1);
        idle(2);
        check("busy_after_break", 8'(busy), 8'h0);

        // 0xFF with a one-sample low glitch in the middle of D3
        push(8'hFF, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 3);
        idle(1);

        // Reset during D4 of 0x3C: frame discarded, outputs back to reset values
        hold_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) hold_bit(1'(8'h3C >> i), 0);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_values("midframe_reset");
        idle(2);

        // Clean 0x5A after the reset
        push(8'h5A, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, -1);
        idle(2);
        check("busy_final", 8'(busy), 8'h0);
        check("frames_outstanding", 8'(exp_q.size()), 8'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
